qspi_mem_arbiter: RTL and testbench
===================================

Name: qspi_mem_arbiter

Overview:
Round-robin arbiter that shares the single QSPI XIP memory controller (ROM/RAM behind qspi_mem_*) between up to NUM_REQ Wishbone-classic requesters (the FazyRV/core variants gated by the en_* pads). It grants one whole bus cycle at a time and forwards the granted requester's signals to the memory-controller port. It routes ack back to that requester and aborts hung transfers with a timeout. It sits inside globefish_soc between the core interconnect and the QSPI memory controller.

Parameters:
NUM_REQ, 8, number of requesters (>=2)
AW, 24, byte address width
DW, 32, data width (sel width = DW/8)
TO_W, 12, timeout counter width; timeout fires after 2**TO_W-1 cycles without ack

Ports:
clk_i  in  1  clock
rst_in  in  1  asynchronous active-low reset
en_i  in  NUM_REQ  requester enable (from en pads); disabled requesters are never granted
req_cyc_i  in  NUM_REQ  per-requester cycle
req_stb_i  in  NUM_REQ  per-requester strobe
req_we_i  in  NUM_REQ  per-requester write enable
req_adr_i  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_dat_i  in  NUM_REQ*DW  packed write data
req_sel_i  in  NUM_REQ*DW/8  packed byte selects
req_dat_o  out  DW  read data, broadcast to all (= mem_dat_i)
req_ack_o  out  NUM_REQ  ack, only to granted requester
req_err_o  out  NUM_REQ  error (timeout), only to granted requester
mem_cyc_o, mem_stb_o, mem_we_o  out  1  to memory controller
mem_adr_o  out  AW
mem_dat_o  out  DW
mem_sel_o  out  DW/8
mem_dat_i  in  DW
mem_ack_i  in  1
grant_o  out  NUM_REQ  registered one-hot grant (debug/status)
timeout_o  out  1  sticky flag, set on any timeout, cleared only by reset

Behaviour:
- Reset: state IDLE, grant_o=0, last pointer=NUM_REQ-1 (requester 0 has first priority), timeout counter=0, timeout_o=0. All mem_* and req_ack/err outputs are 0.
- Eligible requester: en_i[i] & req_cyc_i[i] & req_stb_i[i].
- FSM states:
  - IDLE:
    - If any requester is eligible, pick the first eligible index searching last+1, last+2, ... (wrapping modulo NUM_REQ).
    - Register the one-hot grant and clear the counter. Next state BUSY.
  - BUSY:
    - mem_cyc_o=mem_stb_o=1. mem_we/adr/dat/sel come from a combinational mux of the granted requester, using the registered grant.
    - On mem_ack_i: req_ack_o[g]=mem_ack_i in the same cycle (combinational pass-through). last<=g, grant<=0, next state IDLE.
    - If the granted requester drops cyc or stb, or en_i[g] falls: mem_cyc/stb go to 0 in that same cycle, no ack, last<=g, next state ABORT.
    - Counter increments each BUSY cycle. When it reaches all-ones with no ack: req_err_o[g]=1 for that cycle, timeout_o<=1, next state ABORT.
  - ABORT:
    - One cycle with mem_cyc_o=0 so the controller drops the transfer. grant<=0, next state IDLE.
    - mem_ack_i in ABORT or IDLE is ignored and not forwarded.
- Latency:
  - Request sampled in cycle N; mem_stb_o high in N+1.
  - Minimum one idle cycle between consecutive grants (IDLE bubble), so back-to-back throughput is one transfer per (mem latency + 1) cycles.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins, no err.
  - Ack and requester drop in the same cycle: ack is forwarded, next state IDLE.
  - All requests arriving together: strict rotation, no starvation. Every eligible requester is served within NUM_REQ grants.
- The grant is held for the whole cycle; there is no pre-emption.
- Asynchronous reset mid-transfer: immediate return to reset values; mem_cyc_o drops without completion.

Decomposition:
- Package qspi_arb_pkg holds:
  - state enum {IDLE, BUSY, ABORT}
  - default TO_W constant
  - a helper function for the packed-slice index
- Sub-module rr_prio_pick: combinational rotating-priority picker. Inputs: request vector and last pointer. Outputs: one-hot grant, binary index, and valid.
- The top holds the FSM, timeout counter, output mux and ack/err routing.

Test Plan:
- Single request, 3-cycle ack: req 2 reads adr 0x000100. Expect mem_stb high in cycle 1, req_ack_o=0b00000100 in cycle 3, req_dat_o=mem_dat_i, grant_o back to 0 in cycle 4.
- Contention: requesters 0, 1, 3 hold requests continuously, ack after 1 cycle. Expect grant sequence 0,1,3,0,1,3 with one idle cycle between grants.
- Enable mask: en_i=0b11111110 with req 0 and req 5 active. Expect only 5 granted; req 0 never acked.
- Timeout, TO_W=4: mem_ack_i held low. Expect req_err_o[g]=1 after 15 BUSY cycles, then one ABORT cycle with mem_cyc_o=0, and timeout_o=1 sticky. A late ack is ignored.
- Abort: the granted requester drops cyc in its 2nd BUSY cycle. Expect mem_cyc_o=0 in the same cycle, no ack/err, and the next eligible requester is granted after ABORT+IDLE.
- Reset mid-BUSY: assert rst_in low asynchronously. Expect all outputs 0 immediately; after release, requester 0 wins a simultaneous 0/7 request.

Source files
------------

// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_TO_W    : default width of the no-ack timeout counter
//   slice_lo()  : low bit index of element idx in a packed bus of width-bit elements
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int DEF_TO_W = 12;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the requester served last; search starts at last_i+1
//   grant_o : one-hot winner (all zero when nothing requests)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module rr_prio_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk from the farthest candidate to the nearest one so that the
    // nearest requester after last_i is the final (winning) assignment.
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic QSPI memory-controller
// port among NUM_REQ requesters. One whole bus cycle is granted at a time.
//   clk_i, rst_in              : clock, asynchronous active-low reset
//   en_i                       : requester enables; disabled requesters are never granted
//   req_cyc/stb/we/adr/dat/sel : packed requester buses (requester i at slice i)
//   req_dat_o                  : read data broadcast to every requester
//   req_ack_o, req_err_o       : ack / timeout error, routed to the granted requester only
//   mem_*                      : memory-controller master port
//   grant_o                    : registered one-hot grant
//   timeout_o                  : sticky flag, set by any timeout, cleared by reset
module qspi_mem_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      en_i,
  input  logic [NUM_REQ-1:0]      req_cyc_i,
  input  logic [NUM_REQ-1:0]      req_stb_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [NUM_REQ*AW-1:0]   req_adr_i,
  input  logic [NUM_REQ*DW-1:0]   req_dat_i,
  input  logic [NUM_REQ*DW/8-1:0] req_sel_i,
  output logic [DW-1:0]           req_dat_o,
  output logic [NUM_REQ-1:0]      req_ack_o,
  output logic [NUM_REQ-1:0]      req_err_o,
  output logic                    mem_cyc_o,
  output logic                    mem_stb_o,
  output logic                    mem_we_o,
  output logic [AW-1:0]           mem_adr_o,
  output logic [DW-1:0]           mem_dat_o,
  output logic [DW/8-1:0]         mem_sel_o,
  input  logic [DW-1:0]           mem_dat_i,
  input  logic                    mem_ack_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DW / 8;

  arb_state_e         r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [IW-1:0]      r_gidx, w_gidx_next;
  logic [IW-1:0]      r_last, w_last_next;
  logic [TO_W-1:0]    r_cnt, w_cnt_next;
  logic               r_timeout, w_timeout_next;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_busy;
  logic               w_g_live;

  logic [AW-1:0] w_adr_arr [NUM_REQ];
  logic [DW-1:0] w_dat_arr [NUM_REQ];
  logic [SW-1:0] w_sel_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_adr_arr[gi] = req_adr_i[slice_lo(gi, AW) +: AW];
      assign w_dat_arr[gi] = req_dat_i[slice_lo(gi, DW) +: DW];
      assign w_sel_arr[gi] = req_sel_i[slice_lo(gi, SW) +: SW];
    end
  endgenerate

  assign w_elig = en_i & req_cyc_i & req_stb_i;

  rr_prio_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (w_elig),
    .last_i  (r_last),
    .grant_o (w_pick_onehot),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  assign w_busy   = (r_state == BUSY);
  // Granted requester still wants the bus (enabled, cyc and stb all high).
  assign w_g_live = w_elig[r_gidx];

  // Payload is muxed from the registered grant index and forced to zero
  // outside BUSY so the controller never sees stale address/data.
  assign mem_we_o  = w_busy & req_we_i[r_gidx];
  assign mem_adr_o = {AW{w_busy}} & w_adr_arr[r_gidx];
  assign mem_dat_o = {DW{w_busy}} & w_dat_arr[r_gidx];
  assign mem_sel_o = {SW{w_busy}} & w_sel_arr[r_gidx];

  assign req_dat_o = mem_dat_i;
  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_gidx_next    = r_gidx;
    w_last_next    = r_last;
    w_cnt_next     = r_cnt;
    w_timeout_next = r_timeout;
    mem_cyc_o      = 1'b0;
    mem_stb_o      = 1'b0;
    req_ack_o      = '0;
    req_err_o      = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_next = w_pick_onehot;
          w_gidx_next  = w_pick_idx;
          w_cnt_next   = '0;
          w_state_next = BUSY;
        end
      end

      BUSY: begin
        // Dropping the request withdraws cyc/stb in the same cycle.
        mem_cyc_o  = w_g_live;
        mem_stb_o  = w_g_live;
        w_cnt_next = r_cnt + TO_W'(1);
        // Priority: ack beats both a requester drop and a timeout.
        if (mem_ack_i) begin
          req_ack_o    = r_grant;
          w_last_next  = r_gidx;
          w_grant_next = '0;
          w_state_next = IDLE;
        end else if (!w_g_live) begin
          w_last_next  = r_gidx;
          w_state_next = ABORT;
        end else if (&r_cnt) begin
          req_err_o      = r_grant;
          w_timeout_next = 1'b1;
          w_last_next    = r_gidx;
          w_state_next   = ABORT;
        end
      end

      ABORT: begin
        // One cycle with cyc low so the controller abandons the transfer;
        // any ack arriving now is deliberately dropped.
        w_grant_next = '0;
        w_state_next = IDLE;
      end

      default: begin
        w_grant_next = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_gidx    <= w_gidx_next;
      r_last    <= w_last_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Scoreboard bench for qspi_mem_arbiter. Stimulus issues bursts of
// simultaneous requests; the expected service order follows from plain
// round-robin rotation over the eligible set. A monitor pops and compares
// whenever the DUT presents ack, err or a dropped cycle.
module tb_qspi_mem_arbiter;

  localparam int N      = 8;
  localparam int AW     = 24;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int TO_W   = 4;
  localparam int TO_CYC = 1 << TO_W;   // BUSY cycle in which a hung transfer errors
  // Transfer kinds, encoded in the top two address bits.
  localparam int K_NORM = 0;           // memory acks after 1..3 cycles
  localparam int K_HANG = 1;           // memory never acks -> timeout
  localparam int K_DROP = 2;           // requester drops cyc in 2nd BUSY cycle
  localparam int K_SLOW = 3;           // ack arrives in the timeout cycle

  typedef struct {
    int            idx;
    int            kind;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en, cyc, stb, we;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdat;
  logic [N*SW-1:0] sel;
  logic [DW-1:0] rdat;
  logic [N-1:0]  ack, err, grant;
  logic          m_cyc, m_stb, m_we, m_ack, tout;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdat, m_rdat;
  logic [SW-1:0] m_sel;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           model_last = N - 1;
  bit           model_to = 1'b0;
  bit [N-1:0]   done_v = '0;
  bit           burst_start = 1'b0;
  bit           burst_expect = 1'b0;

  always #5 clk = ~clk;

  qspi_mem_arbiter #(
    .NUM_REQ (N),
    .AW      (AW),
    .DW      (DW),
    .TO_W    (TO_W)
  ) dut (
    .clk_i     (clk),
    .rst_in    (rst_n),
    .en_i      (en),
    .req_cyc_i (cyc),
    .req_stb_i (stb),
    .req_we_i  (we),
    .req_adr_i (adr),
    .req_dat_i (wdat),
    .req_sel_i (sel),
    .req_dat_o (rdat),
    .req_ack_o (ack),
    .req_err_o (err),
    .mem_cyc_o (m_cyc),
    .mem_stb_o (m_stb),
    .mem_we_o  (m_we),
    .mem_adr_o (m_adr),
    .mem_dat_o (m_wdat),
    .mem_sel_o (m_sel),
    .mem_dat_i (m_rdat),
    .mem_ack_i (m_ack),
    .grant_o   (grant),
    .timeout_o (tout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
    return {a[7:0], a} ^ 32'h5A3C_96E1;
  endfunction

  function automatic int pick_kind(input int forced);
    int r;
    if (forced >= 0) return forced;
    r = $urandom_range(0, 19);
    if (r < 14) return K_NORM;
    if (r < 16) return K_HANG;
    if (r < 18) return K_DROP;
    return K_SLOW;
  endfunction

  // 0 = ack, 1 = err, 2 = dropped without response
  function automatic int want_type(input int kind);
    if (kind == K_HANG) return 1;
    if (kind == K_DROP) return 2;
    return 0;
  endfunction

  // Memory-controller model
  initial begin
    int cnt, lat;
    bit err_seen;
    cnt = 0; lat = 0; err_seen = 1'b0;
    m_ack = 1'b0; m_rdat = '0;
    forever begin
      @(negedge clk);
      err_seen = (err != '0);
      @(posedge clk);
      #2;
      m_ack  = 1'b0;
      m_rdat = $urandom;
      if (!rst_n) begin
        cnt = 0;
        continue;
      end
      if (m_cyc && m_stb) begin
        cnt++;
        if (cnt == 1) begin
          if (int'(m_adr[AW-1 -: 2]) == K_NORM)      lat = $urandom_range(1, 3);
          else if (int'(m_adr[AW-1 -: 2]) == K_SLOW) lat = TO_CYC;
          else                                        lat = 0;
        end
        if (cnt == lat) begin
          m_ack  = 1'b1;
          m_rdat = rd_data(m_adr);
        end
      end else begin
        cnt = 0;
        if (err_seen) m_ack = 1'b1;                                   // late ack in ABORT
        else if (grant == '0 && $urandom_range(0, 7) == 0) m_ack = 1'b1; // stray ack in IDLE
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_cyc, prev_term, chk_bubble, chk_issue, issue_exp;
    int   run, prev_run, got;
    exp_t e;
    logic [N-1:0] oh;
    prev_cyc = 0; prev_term = 0; chk_bubble = 0; chk_issue = 0; issue_exp = 0;
    run = 0; prev_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cyc = 0; prev_term = 0; chk_bubble = 0; chk_issue = 0; run = 0;
        continue;
      end
      if (chk_issue) begin
        chk("stb one cycle after request", m_stb, issue_exp);
        chk_issue = 0;
      end
      if (burst_start) begin
        chk_issue   = 1;
        issue_exp   = burst_expect;
        burst_start = 0;
      end
      if (chk_bubble) begin
        chk("cyc low after response", m_cyc, 1'b0);
        chk_bubble = 0;
      end
      prev_run = run;
      run = m_cyc ? run + 1 : 0;

      if (ack != '0 || err != '0) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected response: ack=%b err=%b, none outstanding at %0t", ack, err, $time);
        end else begin
          e = exp_q.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          got = (err != '0) ? 1 : 0;
          chk("response type", got, want_type(e.kind));
          chk("ack vector", ack, (got == 0) ? oh : '0);
          chk("err vector", err, (got == 1) ? oh : '0);
          chk("grant", grant, oh);
          chk("mem adr", m_adr, e.adr);
          chk("mem we", m_we, e.we);
          chk("mem wdata", m_wdat, e.dat);
          chk("mem sel", m_sel, e.sel);
          if (got == 0) chk("read data", rdat, rd_data(e.adr));
          if (e.kind == K_HANG || e.kind == K_SLOW) chk("busy cycles", run, TO_CYC);
          chk("timeout flag", tout, model_to);
          if (e.kind == K_HANG) model_to = 1'b1;
          done_v[e.idx] = 1'b1;
        end
        chk_bubble = 1;
      end else if (grant != '0 && !m_cyc && prev_cyc && !prev_term) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected drop: grant=%b, none outstanding at %0t", grant, $time);
        end else begin
          e = exp_q.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          chk("response type", 2, want_type(e.kind));
          chk("drop grant", grant, oh);
          chk("drop busy cycles", prev_run, 1);
          chk("timeout flag", tout, model_to);
        end
        chk_bubble = 1;
      end
      prev_cyc  = m_cyc;
      prev_term = (ack != '0 || err != '0);
    end
  end

  // One burst: all of set_m request together; served in rotation order.
  task automatic run_burst(input logic [N-1:0] en_m, input logic [N-1:0] set_m,
                           input int first_kind, input int rest_kind);
    int           kind_a[N];
    int           bcnt[N];
    int           ord[$];
    int           j, budget;
    logic [N-1:0] pending;
    logic [AW-1:0] a;
    exp_t         e;

    for (int k = 1; k <= N; k++) begin
      j = (model_last + k) % N;
      if (set_m[j] && en_m[j]) ord.push_back(j);
    end
    for (int i = 0; i < N; i++) begin
      kind_a[i] = pick_kind(rest_kind);
      bcnt[i]   = 0;
    end
    if (ord.size() > 0 && first_kind >= 0) kind_a[ord[0]] = first_kind;

    @(posedge clk);
    #1;
    done_v = '0;
    for (int i = 0; i < N; i++) begin
      a = AW'($urandom);
      a[AW-1 -: 2] = 2'(kind_a[i]);
      adr[i*AW +: AW]  = a;
      wdat[i*DW +: DW] = $urandom;
      sel[i*SW +: SW]  = SW'($urandom_range(1, (1 << SW) - 1));
      we[i]            = 1'($urandom_range(0, 1));
    end
    foreach (ord[k]) begin
      e.idx  = ord[k];
      e.kind = kind_a[ord[k]];
      e.adr  = adr[ord[k]*AW +: AW];
      e.we   = we[ord[k]];
      e.dat  = wdat[ord[k]*DW +: DW];
      e.sel  = sel[ord[k]*SW +: SW];
      exp_q.push_back(e);
    end
    if (ord.size() > 0) model_last = ord[ord.size() - 1];
    en  = en_m;
    cyc = set_m;
    stb = set_m;
    burst_expect = (ord.size() > 0);
    burst_start  = 1'b1;

    pending = set_m & en_m;
    budget  = 25 * N + 10;
    while (pending != '0 && budget > 0) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pending[i]) begin
          if (done_v[i]) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; pending[i] = 1'b0; done_v[i] = 1'b0;
          end else if (kind_a[i] == K_DROP && grant[i]) begin
            bcnt[i]++;
            if (bcnt[i] == 2) begin
              cyc[i] = 1'b0; pending[i] = 1'b0;
            end
          end
        end
      end
      budget--;
    end
    if (pending != '0) begin
      vectors++; miscompares++;
      $display("FAIL burst service: requesters %b still waiting, expected none", pending);
    end
    repeat (3) @(posedge clk);
    #1;
    cyc = '0;
    stb = '0;
    @(posedge clk);
    #1;
    chk("responses outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [N-1:0] en_m, set_m;
    rst_n = 1'b0;
    en = '1; cyc = '1; stb = '1; we = '1;
    adr = '0; wdat = '0; sel = '1;
    repeat (2) @(posedge clk);
    #3;
    // Reset state, even with every requester asking for the bus
    chk("reset mem_cyc", m_cyc, 1'b0);
    chk("reset mem_stb", m_stb, 1'b0);
    chk("reset mem_we", m_we, 1'b0);
    chk("reset mem_adr", m_adr, '0);
    chk("reset mem_dat", m_wdat, '0);
    chk("reset mem_sel", m_sel, '0);
    chk("reset grant", grant, '0);
    chk("reset ack", ack, '0);
    chk("reset err", err, '0);
    chk("reset timeout", tout, 1'b0);
    cyc = '0; stb = '0; we = '0;
    #1 rst_n = 1'b1;

    run_burst('1, 8'b0000_0100, K_NORM, K_NORM);        // single request
    run_burst('1, 8'b0000_1011, K_NORM, K_NORM);        // contention 0/1/3
    run_burst('1, 8'b0000_1011, K_NORM, K_NORM);
    run_burst(8'b1111_1110, 8'b0010_0001, K_NORM, -1);  // enable mask
    run_burst('1, 8'b0001_0000, K_HANG, K_NORM);        // timeout + late ack
    run_burst('1, 8'b0100_0010, K_DROP, K_NORM);        // requester abort
    run_burst('1, 8'b0010_0000, K_SLOW, K_NORM);        // ack in timeout cycle
    run_burst('1, 8'b1111_1111, K_NORM, K_NORM);        // all at once

    for (int b = 0; b < 60; b++) begin
      en_m = '0;
      for (int i = 0; i < N; i++) en_m[i] = ($urandom_range(0, 7) != 0);
      set_m = N'($urandom_range(1, (1 << N) - 1));
      run_burst(en_m, set_m, -1, -1);
    end

    // Asynchronous reset in the middle of a hung transfer
    @(posedge clk);
    #1;
    en = '1;
    adr[3*AW +: AW] = {2'(K_HANG), 22'h000100};
    cyc[3] = 1'b1; stb[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mem_cyc", m_cyc, 1'b0);
    chk("async reset mem_stb", m_stb, 1'b0);
    chk("async reset grant", grant, '0);
    chk("async reset timeout", tout, 1'b0);
    chk("async reset err", err, '0);
    cyc = '0; stb = '0;
    exp_q.delete();
    model_last = N - 1;
    model_to   = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_burst('1, 8'b1000_0001, K_NORM, K_NORM);        // 0 beats 7 after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
